// File: rtl/fanout_fork_buffer.sv
// Eager fork: buffers one upstream stream and broadcasts the FIFO head to NUM_OUT lanes,
// popping only once every enabled lane has taken it.
module fanout_fork_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_OUT    = 6,
    parameter int DEPTH      = 2
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESET,
    input  logic                  flush,
    input  logic [NUM_OUT-1:0]    cfg_en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] storage_q [DEPTH];
    logic [DATA_WIDTH-1:0] storage_d [DEPTH];
    logic [CW-1:0]         count_q, count_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [NUM_OUT-1:0]    taken_q, taken_d;

    logic               full, empty, push, pop;
    logic [NUM_OUT-1:0] done;

    // in_ready comes only from registered count and flush, never from out_ready.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        in_ready  = ~full & ~flush;
        push      = in_valid & in_ready;
        out_data  = storage_q[rd_ptr_q];
        out_valid = {NUM_OUT{~empty}} & cfg_en & ~taken_q;
        done      = ~cfg_en | taken_q | out_ready;
        pop       = ~empty & (&done);
    end

    always_comb begin
        storage_d = storage_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        taken_d   = taken_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            taken_d  = '0;
        end else begin
            if (push) begin
                storage_d[wr_ptr_q] = in_data;
                wr_ptr_d            = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                taken_d  = '0;
            end else begin
                taken_d = taken_q | (out_valid & out_ready);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_q[i] <= '0;
            end
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            taken_q  <= '0;
        end else begin
            storage_q <= storage_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            taken_q   <= taken_d;
        end
    end

endmodule

// File: tb/tb_fanout_fork_buffer.sv
// Bench for fanout_fork_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_fanout_fork_buffer;
    localparam int DW    = 16;
    localparam int NO    = 6;
    localparam int DEPTH = 2;

    logic          CLK = 1'b0;
    logic          ASYNCRESET;
    logic          flush;
    logic [NO-1:0] cfg_en;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [NO-1:0] out_valid;
    logic [NO-1:0] out_ready;

    int errors = 0;
    int checks = 0;

    // model: tokens held in order, plus which lanes already have the head
    logic [DW-1:0] mq [$];
    logic [NO-1:0] mtk;

    fanout_fork_buffer #(.DATA_WIDTH(DW), .NUM_OUT(NO), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .flush(flush), .cfg_en(cfg_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 CLK = ~CLK;

    function automatic logic [NO-1:0] m_valid();
        if (mq.size() == 0) return '0;
        return cfg_en & ~mtk;
    endfunction

    function automatic logic m_ready();
        return (mq.size() < DEPTH) && !flush;
    endfunction

    task automatic drive(input logic f, input logic v, input logic [DW-1:0] d,
                         input logic [NO-1:0] en, input logic [NO-1:0] rdy);
        @(negedge CLK);
        flush = f; in_valid = v; in_data = d; cfg_en = en; out_ready = rdy;
        #1;
    endtask

    task automatic advance();
        logic [NO-1:0] vexp;
        logic pu, po;
        vexp = m_valid();
        pu   = in_valid && m_ready();
        po   = (mq.size() != 0) && ((~cfg_en | mtk | out_ready) == '1);
        @(posedge CLK);
        if (flush) begin
            mq.delete();
            mtk = '0;
        end else begin
            if (po) begin
                mq.delete(0);
                mtk = '0;
            end else begin
                mtk = mtk | (vexp & out_ready);
            end
            if (pu) mq.push_back(in_data);
        end
    endtask

    task automatic test_reset();
        ASYNCRESET = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        cfg_en = '1; out_ready = '1;
        mq.delete(); mtk = '0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_out_valid got=%h exp=00", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        @(negedge CLK);
        ASYNCRESET = 1'b0;
    endtask

    task automatic test_single();
        drive(1'b0, 1'b1, 16'h00A1, '1, '1);
        checks++; if (in_ready !== 1'b1 || out_valid !== '0) begin errors++; $display("FAIL single_t0 got rdy=%b v=%h exp rdy=1 v=00", in_ready, out_valid); end
        advance();
        drive(1'b0, 1'b0, '0, '1, '1);
        checks++; if (out_valid !== 6'h3F) begin errors++; $display("FAIL single_t1_valid got=%h exp=3f", out_valid); end
        checks++; if (out_data !== 16'h00A1) begin errors++; $display("FAIL single_t1_data got=%h exp=00a1", out_data); end
        advance();
        drive(1'b0, 1'b0, '0, '1, '1);
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL single_t2_valid got=%h exp=00", out_valid); end
        advance();
    endtask

    task automatic test_slow_lane();
        logic [NO-1:0] ev [5];
        ev = '{6'b000011, 6'b000010, 6'b000010, 6'b000010, 6'b000000};
        drive(1'b0, 1'b1, 16'h00B2, 6'b000011, 6'b000011);
        advance();
        for (int t = 0; t < 5; t++) begin
            drive(1'b0, 1'b0, '0, 6'b000011, (t < 3) ? 6'b000001 : 6'b000011);
            checks++; if (out_valid !== ev[t]) begin errors++; $display("FAIL slow_valid t=%0d got=%h exp=%h", t, out_valid, ev[t]); end
            if (t < 4) begin
                checks++; if (out_data !== 16'h00B2) begin errors++; $display("FAIL slow_data t=%0d got=%h exp=00b2", t, out_data); end
            end
            advance();
        end
    endtask

    task automatic test_fill();
        int sent;
        int gotn [NO];
        logic v;
        sent = 0;
        for (int i = 0; i < NO; i++) gotn[i] = 0;
        for (int c = 0; c < 12; c++) begin
            v = (sent < 3);
            drive(1'b0, v, DW'(sent + 1), '1, (c < 4) ? '0 : '1);
            checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL fill_in_ready c=%0d got=%b exp=%b", c, in_ready, m_ready()); end
            checks++; if (out_valid !== m_valid()) begin errors++; $display("FAIL fill_valid c=%0d got=%h exp=%h", c, out_valid, m_valid()); end
            if (c == 2) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got=%b exp=0", in_ready); end
            end
            for (int i = 0; i < NO; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    checks++;
                    if (out_data !== DW'(gotn[i] + 1)) begin errors++; $display("FAIL fill_order lane=%0d got=%h exp=%h", i, out_data, DW'(gotn[i] + 1)); end
                    gotn[i]++;
                end
            end
            if (v && m_ready()) sent++;
            advance();
        end
        for (int i = 0; i < NO; i++) begin
            checks++; if (gotn[i] != 3) begin errors++; $display("FAIL fill_count lane=%0d got=%0d exp=3", i, gotn[i]); end
        end
    endtask

    task automatic test_disabled();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, (c < 4), DW'(16'h0100 + c), '0, NO'($urandom));
            checks++; if (out_valid !== '0) begin errors++; $display("FAIL dis_valid c=%0d got=%h exp=00", c, out_valid); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dis_in_ready c=%0d got=%b exp=1", c, in_ready); end
            advance();
        end
        drive(1'b0, 1'b0, '0, '1, '0);
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL dis_empty got=%h exp=00", out_valid); end
        advance();
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b1, 16'h00C1, '1, '0);
        advance();
        drive(1'b0, 1'b1, 16'h00C2, '1, '0);
        advance();
        drive(1'b0, 1'b0, '0, '1, 6'b000100);
        checks++; if (out_valid !== 6'h3F || out_data !== 16'h00C1) begin errors++; $display("FAIL flush_pre got v=%h d=%h exp v=3f d=00c1", out_valid, out_data); end
        advance();
        drive(1'b1, 1'b1, 16'h00EE, '1, '0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 6'b111011) begin errors++; $display("FAIL flush_valid got=%h exp=3b", out_valid); end
        advance();
        drive(1'b0, 1'b1, 16'h00D5, '1, '0);
        checks++; if (out_valid !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_after got v=%h rdy=%b exp v=00 rdy=1", out_valid, in_ready); end
        advance();
        drive(1'b0, 1'b0, '0, '1, '1);
        checks++; if (out_valid !== 6'h3F || out_data !== 16'h00D5) begin errors++; $display("FAIL flush_next got v=%h d=%h exp v=3f d=00d5", out_valid, out_data); end
        advance();
        drive(1'b0, 1'b0, '0, '1, '1);
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL flush_drain got=%h exp=00", out_valid); end
        advance();
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 16'h00E1, '1, '0);
        advance();
        drive(1'b0, 1'b1, 16'h00E2, '1, '0);
        advance();
        drive(1'b0, 1'b0, '0, '1, '0);
        #2 ASYNCRESET = 1'b1;
        #1;
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL arst_valid got=%h exp=00", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL arst_data got=%h exp=0000", out_data); end
        mq.delete(); mtk = '0;
        @(posedge CLK);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        drive(1'b0, 1'b0, '0, '1, '1);
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL arst_release got=%h exp=00", out_valid); end
        advance();
        drive(1'b0, 1'b1, 16'h00E3, '1, '1);
        advance();
        drive(1'b0, 1'b0, '0, '1, '1);
        checks++; if (out_valid !== 6'h3F || out_data !== 16'h00E3) begin errors++; $display("FAIL arst_new got v=%h d=%h exp v=3f d=00e3", out_valid, out_data); end
        advance();
    endtask

    task automatic test_random();
        logic [NO-1:0] en;
        en = '1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) en = NO'($urandom);
            drive(($urandom_range(0, 19) == 0), 1'($urandom), DW'($urandom), en, NO'($urandom));
            checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, m_ready()); end
            checks++; if (out_valid !== m_valid()) begin errors++; $display("FAIL rnd_valid c=%0d got=%h exp=%h", c, out_valid, m_valid()); end
            if (mq.size() != 0) begin
                checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_data, mq[0]); end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_slow_lane();
        test_fill();
        test_disabled();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
